scan_chain_ctrl: RTL and testbench

SCAN_CHAIN_CTRL -- requirements
Module: scan_chain_ctrl

---
 rtl/scan_pkg.sv | 5 +
 rtl/scan_if.sv | 19 +
 rtl/scan_shift_cnt.sv | 21 ++
 rtl/scan_chain_ctrl.sv | 71 +++++++
 tb/tb_scan_chain_ctrl.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/scan_pkg.sv
// scan_pkg: shared FSM state type and default chain length for the scan controller
package scan_pkg;
    localparam int CHAIN_LEN_DEF = 16;
    typedef enum logic [2:0] {IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, DONE} scan_state_t;
endpackage

// File: rtl/scan_if.sv
// scan_if: test request/response handshake plus serial chain signals
interface scan_if
    import scan_pkg::*;
#(parameter int CHAIN_LEN = CHAIN_LEN_DEF) ();
    logic                 start;
    logic [CHAIN_LEN-1:0] vec_in;
    logic [CHAIN_LEN-1:0] exp_in;
    logic                 scan_en;
    logic                 scan_in;
    logic                 scan_out;
    logic                 busy;
    logic                 done;
    logic [CHAIN_LEN-1:0] resp_out;
    logic                 mismatch;
    modport master (output start, vec_in, exp_in, scan_out,
                    input  scan_en, scan_in, busy, done, resp_out, mismatch);
    modport slave  (input  start, vec_in, exp_in, scan_out,
                    output scan_en, scan_in, busy, done, resp_out, mismatch);
endinterface

// File: rtl/scan_shift_cnt.sv
// scan_shift_cnt: phase counter that saturates at CHAIN_LEN-1 and flags terminal count
module scan_shift_cnt
    import scan_pkg::*;
#(parameter int CHAIN_LEN = CHAIN_LEN_DEF)
(
    input  logic CK,
    input  logic RN,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int W = $clog2(CHAIN_LEN);
    localparam logic [W-1:0] LAST = W'(CHAIN_LEN - 1);
    logic [W-1:0] cnt;
    assign tc = (cnt == LAST);
    // count up while enabled, holding at the terminal value so a phase never wraps
    always_ff @(posedge CK) begin
        if (!RN || clr) cnt <= '0;
        else if (en && !tc) cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl: shifts a stimulus into a scan chain, captures, shifts the response out and compares it
module scan_chain_ctrl
    import scan_pkg::*;
#(parameter int CHAIN_LEN = CHAIN_LEN_DEF)
(
    input  logic CK,
    input  logic RN,
    scan_if.slave bus
);
    scan_state_t          state, state_nx;
    logic [CHAIN_LEN-1:1] vec_sh;
    logic [CHAIN_LEN-2:0] resp_sh;
    logic [CHAIN_LEN-1:0] exp_q, resp_nx;
    logic                 cnt_clr, cnt_en, tc;
    logic                 scan_en_nx, scan_in_nx;
    scan_shift_cnt #(.CHAIN_LEN(CHAIN_LEN)) u_cnt (
        .CK  (CK),
        .RN  (RN),
        .clr (cnt_clr),
        .en  (cnt_en),
        .tc  (tc)
    );
    // next state, counter control and the values every output flop takes next cycle
    always_comb begin
        state_nx = state;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;
        case (state)
            IDLE:      if (bus.start) begin state_nx = SHIFT_IN; cnt_clr = 1'b1; end
            SHIFT_IN:  begin cnt_en = 1'b1; if (tc) begin state_nx = CAPTURE; cnt_clr = 1'b1; end end
            CAPTURE:   begin state_nx = SHIFT_OUT; cnt_clr = 1'b1; end
            SHIFT_OUT: begin cnt_en = 1'b1; if (tc) begin state_nx = DONE; cnt_clr = 1'b1; end end
            default:   state_nx = IDLE;
        endcase
        resp_nx    = {bus.scan_out, resp_sh};
        scan_en_nx = (state_nx == SHIFT_IN) || (state_nx == SHIFT_OUT);
        scan_in_nx = (state_nx == SHIFT_IN) && (state == IDLE ? bus.vec_in[0] : vec_sh[1]);
    end
    // state register, registered outputs and the stimulus/response shifters
    always_ff @(posedge CK) begin
        if (!RN) begin
            state        <= IDLE;
            vec_sh       <= '0;
            resp_sh      <= '0;
            exp_q        <= '0;
            bus.scan_en  <= 1'b0;
            bus.scan_in  <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.resp_out <= '0;
            bus.mismatch <= 1'b0;
        end else begin
            state       <= state_nx;
            bus.scan_en <= scan_en_nx;
            bus.scan_in <= scan_in_nx;
            bus.busy    <= state_nx != IDLE;
            bus.done    <= state_nx == DONE;
            if (state == IDLE && bus.start) begin
                vec_sh <= bus.vec_in[CHAIN_LEN-1:1];
                exp_q  <= bus.exp_in;
            end else if (state == SHIFT_IN) begin
                vec_sh <= vec_sh >> 1;
            end
            if (state == SHIFT_OUT) resp_sh <= resp_nx[CHAIN_LEN-1:1];
            if (state == SHIFT_OUT && tc) begin
                bus.resp_out <= resp_nx;
                bus.mismatch <= resp_nx != exp_q;
            end
        end
    end
endmodule

// File: tb/tb_scan_chain_ctrl.sv
// tb_scan_chain_ctrl: directed and random tests of two controller instances driving inverting scan chains
module tb_scan_chain_ctrl;
    logic CK = 1'b0;
    logic RN = 1'b0;
    logic chk = 1'b0;
    int   tests = 0;
    int   fails = 0;
    always #5 CK = ~CK;
    scan_if #(.CHAIN_LEN(8)) if8 ();
    scan_if #(.CHAIN_LEN(2)) if2 ();
    scan_chain_ctrl #(.CHAIN_LEN(8)) dut8 (.CK(CK), .RN(RN), .bus(if8.slave));
    scan_chain_ctrl #(.CHAIN_LEN(2)) dut2 (.CK(CK), .RN(RN), .bus(if2.slave));
    // chains under test: shift when enabled, otherwise capture the inverse of their contents
    logic [7:0] ch8 = '0;
    logic [1:0] ch2 = '0;
    always @(posedge CK) begin
        ch8 <= if8.scan_en ? {ch8[6:0], if8.scan_in} : ~ch8;
        ch2 <= if2.scan_en ? {ch2[0], if2.scan_in} : ~ch2;
    end
    assign if8.scan_out = ch8[7];
    assign if2.scan_out = ch2[1];
    // per-instance views so the model and checker can loop over both
    logic        st[2], bsy[2], dn[2], sen[2], sin[2], mis[2];
    logic [63:0] vin[2], ein[2], resp[2];
    assign st[0] = if8.start;     assign st[1] = if2.start;
    assign bsy[0] = if8.busy;     assign bsy[1] = if2.busy;
    assign dn[0] = if8.done;      assign dn[1] = if2.done;
    assign sen[0] = if8.scan_en;  assign sen[1] = if2.scan_en;
    assign sin[0] = if8.scan_in;  assign sin[1] = if2.scan_in;
    assign mis[0] = if8.mismatch; assign mis[1] = if2.mismatch;
    assign vin[0] = 64'(if8.vec_in);    assign vin[1] = 64'(if2.vec_in);
    assign ein[0] = 64'(if8.exp_in);    assign ein[1] = 64'(if2.exp_in);
    assign resp[0] = 64'(if8.resp_out); assign resp[1] = 64'(if2.resp_out);
    // model: mt = edges since acceptance (-1 when idle); the chain returns the inverse of the stimulus
    int          nl[2] = '{8, 2};
    int          mt[2] = '{-1, -1};
    logic [63:0] mvec[2], mexp[2], mresp[2];
    logic        mmis[2];
    always @(posedge CK) begin
        for (int d = 0; d < 2; d++) begin
            if (!RN) begin
                mt[d] = -1; mresp[d] = '0; mmis[d] = 1'b0;
            end else if (mt[d] < 0) begin
                if (st[d]) begin mt[d] = 0; mvec[d] = vin[d]; mexp[d] = ein[d]; end
            end else begin
                mt[d]++;
                if (mt[d] == 2 * nl[d] + 1) begin
                    mresp[d] = ~mvec[d] & ((64'd1 << nl[d]) - 64'd1);
                    mmis[d]  = mresp[d] != mexp[d];
                end else if (mt[d] > 2 * nl[d] + 1) begin
                    mt[d] = -1;
                end
            end
        end
    end
    task automatic check(input string nm, input int d, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s dut%0d at %0t: got %0h expected %0h", nm, d, $time, got, want);
        end
    endtask
    // every-cycle comparison of all outputs against the model
    always @(negedge CK) begin
        if (chk) begin
            for (int d = 0; d < 2; d++) begin
                check("busy", d, 64'(bsy[d]), 64'(mt[d] >= 0));
                check("done", d, 64'(dn[d]), 64'(mt[d] == 2 * nl[d] + 1));
                check("scan_en", d, 64'(sen[d]), 64'((mt[d] >= 0 && mt[d] < nl[d]) || (mt[d] > nl[d] && mt[d] <= 2 * nl[d])));
                check("scan_in", d, 64'(sin[d]), 64'((mt[d] >= 0 && mt[d] < nl[d]) ? mvec[d][mt[d]] : 1'b0));
                check("resp_out", d, resp[d], mresp[d]);
                check("mismatch", d, 64'(mis[d]), 64'(mmis[d]));
            end
        end
    end
    // one test on the 8-cell instance; lat counts cycles from presenting start to seeing done
    task automatic run8(input logic [7:0] v, input logic [7:0] e, input bit tog, output int lat, output int ones);
        if8.vec_in = v; if8.exp_in = e; if8.start = 1'b1; lat = -1; ones = 0;
        for (int n = 1; n <= 60 && lat < 0; n++) begin
            @(negedge CK);
            if (n == 1) if8.start = 1'b0;
            if (tog) if8.vec_in = ~if8.vec_in;
            if (n <= 8 && if8.scan_in) ones++;
            if (if8.done) lat = n;
        end
        @(negedge CK);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
    initial begin
        int lat, ones, nd, first, second;
        if8.start = 1'b0; if8.vec_in = '0; if8.exp_in = '0;
        if2.start = 1'b0; if2.vec_in = '0; if2.exp_in = '0;
        repeat (3) @(negedge CK);
        chk = 1'b1;
        check("rst_busy", 0, 64'(if8.busy), 64'd0);
        check("rst_resp", 0, 64'(if8.resp_out), 64'd0);
        RN = 1'b1;
        @(negedge CK);
        run8(8'hA5, 8'h5A, 1'b0, lat, ones);
        check("lat_a5", 0, 64'(lat), 64'd18);
        check("resp_a5", 0, 64'(if8.resp_out), 64'h5A);
        check("mis_a5", 0, 64'(if8.mismatch), 64'd0);
        run8(8'hA5, 8'h5B, 1'b0, lat, ones);
        check("resp_5b", 0, 64'(if8.resp_out), 64'h5A);
        check("mis_5b", 0, 64'(if8.mismatch), 64'd1);
        run8(8'hFF, 8'h00, 1'b1, lat, ones);
        check("ones_ff", 0, 64'(ones), 64'd8);
        check("resp_ff", 0, 64'(if8.resp_out), 64'h00);
        check("lat_ff", 0, 64'(lat), 64'd18);
        if8.vec_in = 8'h3C; if8.exp_in = 8'hC3; if8.start = 1'b1; nd = 0; first = 0; second = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge CK);
            if (if8.done) begin nd++; if (nd == 1) first = n; else second = n; end
        end
        if8.start = 1'b0;
        check("dones_held", 0, 64'(nd), 64'd2);
        check("done_spacing", 0, 64'(second - first), 64'd19);
        repeat (25) @(negedge CK);
        if8.vec_in = 8'h96; if8.exp_in = 8'h69; if8.start = 1'b1;
        for (int n = 1; n <= 14; n++) begin
            @(negedge CK);
            if (n == 1) if8.start = 1'b0;
        end
        RN = 1'b0;
        @(negedge CK);
        check("abort_busy", 0, 64'(if8.busy), 64'd0);
        check("abort_scan_en", 0, 64'(if8.scan_en), 64'd0);
        check("abort_resp", 0, 64'(if8.resp_out), 64'd0);
        RN = 1'b1;
        nd = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge CK);
            if (if8.done) nd++;
        end
        check("abort_no_done", 0, 64'(nd), 64'd0);
        run8(8'h96, 8'h69, 1'b0, lat, ones);
        check("lat_after_abort", 0, 64'(lat), 64'd18);
        check("resp_after_abort", 0, 64'(if8.resp_out), 64'h69);
        if2.vec_in = 2'b01; if2.exp_in = 2'b10; if2.start = 1'b1; lat = -1;
        for (int n = 1; n <= 20 && lat < 0; n++) begin
            @(negedge CK);
            if (n == 1) if2.start = 1'b0;
            if (if2.done) lat = n;
        end
        @(negedge CK);
        check("lat_n2", 1, 64'(lat), 64'd6);
        check("resp_n2", 1, 64'(if2.resp_out), 64'b10);
        check("mis_n2", 1, 64'(if2.mismatch), 64'd0);
        for (int c = 0; c < 800; c++) begin
            @(negedge CK);
            RN = $urandom_range(0, 199) != 0;
            if8.start  = $urandom_range(0, 3) == 0;
            if8.vec_in = 8'($urandom);
            if8.exp_in = $urandom_range(0, 1) ? ~if8.vec_in : 8'($urandom);
            if2.start  = $urandom_range(0, 2) == 0;
            if2.vec_in = 2'($urandom);
            if2.exp_in = $urandom_range(0, 1) ? ~if2.vec_in : 2'($urandom);
        end
        @(negedge CK);
        RN = 1'b1; if8.start = 1'b0; if2.start = 1'b0;
        repeat (30) @(negedge CK);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
